nes_cpu_bus_responder: RTL and testbench
========================================

# nes_cpu_bus_responder

Responder side of the CPU bus: decodes each `Addr_bus`/`R_nW` access from the CPU and serves it.
- Serves 2 KiB work RAM mirrored at $0000-$1FFF, PPU register window $2000-$3FFF, the OAM DMA register $4014 and PRG space $8000-$FFFF.
- Read data comes from the selected target, or from the open-bus latch when no target is selected.
- Sits between the CPU core, the PPU register port and the cartridge PRG port.
- Owns the OAM DMA engine, which stalls the CPU and copies one 256-byte page to PPU $2004.

## Interface
Parameters:
- `RAM_AW`, 11, work RAM address width (2 KiB).
- `DMA_REG`, 16'h4014, OAM DMA trigger address.
- `OAM_REG`, 3'd4, PPU register index written by DMA ($2004).

Ports:
- `clk_ph1`  in  1  the single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Addr_bus`  in  16  CPU address.
- `Data_bus_out`  in  8  CPU write data.
- `R_nW`  in  1  1 = CPU read, 0 = CPU write.
- `Data_bus_in`  out  8  read data to CPU (combinational).
- `cpu_rdy`  out  1  0 = CPU must hold all state (full stall).
- `dma_active`  out  1  DMA engine not IDLE.
- `prg_addr`  out  15  PRG ROM address.
- `prg_data`  in  8  PRG ROM data (combinational).
- `ppu_sel`  out  1  PPU register access this cycle.
- `ppu_addr`  out  3  PPU register index.
- `ppu_we`  out  1  PPU register write strobe.
- `ppu_wdata`  out  8  PPU write data.
- `ppu_rdata`  in  8  PPU read data.

## Operation
Address map (CPU side, only while `dma_active`=0):
- $0000-$1FFF: RAM at `Addr_bus[10:0]`. Read is asynchronous. Write commits on the edge when `R_nW`=0.
- $2000-$3FFF: `ppu_sel`=1, `ppu_addr`=`Addr_bus[2:0]`, `ppu_we`=!`R_nW`, `ppu_wdata`=`Data_bus_out`. Reads return `ppu_rdata`.
- `DMA_REG`, write: latch page P = `Data_bus_out` and start DMA. Read: open bus.
- Other $4000-$7FFF: reads return open bus; writes are ignored.
- $8000-$FFFF: `prg_addr`=`Addr_bus[14:0]`; reads return `prg_data`; writes are ignored.
- Open-bus latch: captures `Data_bus_in` every cycle in which a target drives it. It also captures on CPU writes, with `Data_bus_out`.

DMA state machine:
- States: IDLE, HALT, ALIGN, RD, WR. Free-running parity flop `par` toggles every cycle and resets to 0.
- IDLE -> HALT on a CPU write to `DMA_REG`.
- HALT (1 cycle) -> ALIGN if `par`=1, else RD.
- ALIGN (1 cycle) -> RD.
- RD: source address {P, idx}, decoded as on the CPU side; $40-$7F pages return open bus. The byte goes into `dbuf`. Source PPU pages assert `ppu_sel` with `ppu_we`=0. RD -> WR.
- WR: `ppu_sel`=1, `ppu_addr`=`OAM_REG`, `ppu_we`=1, `ppu_wdata`=`dbuf`; idx increments. WR -> RD, or WR -> IDLE when idx wraps from 255 to 0.
- While `dma_active`=1, CPU bus inputs are ignored and CPU-side PPU strobes are suppressed.

## Timing
- `cpu_rdy`=!`dma_active`; deasserts the cycle after the $4014 write edge.
- Stall length is 513 cycles when HALT has `par`=0, and 514 when `par`=1.
- Reset values: state IDLE, `cpu_rdy`=1, `dma_active`=0, idx 0, P 0, `dbuf` 0, open-bus 0, `par` 0, `ppu_we`=0, `ppu_sel`=0. RAM contents are not reset.
- Reset mid-DMA: IDLE on the next cycle, with no further `ppu_we` pulses.
- A $4014 write while DMA is active cannot occur, because the CPU is stalled. If one is presented anyway, it is ignored.
- idx is 8 bits and wraps naturally; the page never increments.

## Structure
- Shared package `nes_bus_pkg`:
  - address-region constants (RAM_END, PPU_BASE, PPU_END, DMA_REG, PRG_BASE);
  - DMA state encoding.
- One natural sub-module, `oam_dma_engine`: the state machine, parity, idx, P and `dbuf`. It exposes a source address/data handshake and the PPU write strobe.
- The top level keeps the decode, RAM array, output muxing and open-bus latch.

## Test plan
- RAM mirror: write $55 to $0012, then read $0812 and $1812 -> both return $55.
- PRG pass-through: the ROM model returns `prg_addr[7:0]`. Read $FFFC -> `prg_addr`=$7FFC, `Data_bus_in`=$FC. A write to $8000 changes nothing.
- PPU mirror: write $A5 to $3FF9 -> exactly one cycle with `ppu_sel`=1, `ppu_addr`=1, `ppu_we`=1, `ppu_wdata`=$A5.
- DMA, both parities:
  - Preload $0200-$02FF with i^$3C and write $02 to $4014.
  - HALT with `par`=0 -> `cpu_rdy` low for 513 cycles; 256 `ppu_we` pulses at `ppu_addr`=4 carrying data i^$3C in order.
  - HALT with `par`=1 -> 514 cycles, same data.
- Open bus: read $0005 (holding $77), then read $4800 -> $77. Read $4014 -> $77.
- Reset after the 100th DMA write -> next cycle `cpu_rdy`=1 and `dma_active`=0, no further `ppu_we` pulses. RAM at $0200 still holds $3C.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - CPU bus address map, DMA state encoding and region decode
package nes_bus_pkg;

    localparam logic [15:0] RAM_END  = 16'h1FFF;
    localparam logic [15:0] PPU_BASE = 16'h2000;
    localparam logic [15:0] PPU_END  = 16'h3FFF;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] PRG_BASE = 16'h8000;

    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_HALT  = 3'd1;
    localparam logic [2:0] DMA_ALIGN = 3'd2;
    localparam logic [2:0] DMA_RD    = 3'd3;
    localparam logic [2:0] DMA_WR    = 3'd4;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_PPU,
        RGN_DMA,
        RGN_OPEN,
        RGN_PRG
    } region_t;

    // The DMA trigger address is passed in so an overridden top-level
    // parameter is honoured by every decoder.
    function automatic region_t decode_region(input logic [15:0] addr,
                                              input logic [15:0] dma_reg);
        if (addr <= RAM_END)
            return RGN_RAM;
        else if (addr >= PPU_BASE && addr <= PPU_END)
            return RGN_PPU;
        else if (addr == dma_reg)
            return RGN_DMA;
        else if (addr < PRG_BASE)
            return RGN_OPEN;
        else
            return RGN_PRG;
    endfunction

endpackage

// File: rtl/nes_cpu_bus_responder_oam_dma.sv
// rtl/nes_cpu_bus_responder_oam_dma.sv - OAM DMA engine: halt/align, then 256 read/write pairs
// Ports:
//   clk_ph1, rst     clock, synchronous active-high reset
//   start            CPU write to the DMA trigger register this cycle
//   start_page       page P latched on start
//   active           engine not idle (CPU stalled)
//   src_rd           engine is reading its source byte this cycle
//   src_addr         source address {P, idx}
//   src_data         byte returned by the source decode
//   oam_we           write strobe towards the PPU OAM data register
//   oam_wdata        byte captured during the preceding read
module oam_dma_engine
    import nes_bus_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_page,
    output logic        active,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        oam_we,
    output logic [7:0]  oam_wdata
);

    logic [2:0] state;
    logic       par;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] dbuf;

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state <= DMA_IDLE;
            par   <= 1'b0;
            idx   <= 8'd0;
            page  <= 8'd0;
            dbuf  <= 8'd0;
        end else begin
            par <= ~par;
            case (state)
                DMA_IDLE: begin
                    if (start) begin
                        page  <= start_page;
                        idx   <= 8'd0;
                        state <= DMA_HALT;
                    end
                end
                // An odd halt cycle costs one extra alignment cycle.
                DMA_HALT:  state <= par ? DMA_ALIGN : DMA_RD;
                DMA_ALIGN: state <= DMA_RD;
                DMA_RD: begin
                    dbuf  <= src_data;
                    state <= DMA_WR;
                end
                DMA_WR: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? DMA_IDLE : DMA_RD;
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end

    assign active    = (state != DMA_IDLE);
    assign src_rd    = (state == DMA_RD);
    assign src_addr  = {page, idx};
    assign oam_we    = (state == DMA_WR);
    assign oam_wdata = dbuf;

endmodule

// File: rtl/nes_cpu_bus_responder.sv
// rtl/nes_cpu_bus_responder.sv - CPU bus responder: RAM, PPU window, OAM DMA, PRG and open bus
// Ports:
//   clk_ph1, rst                   clock, synchronous active-high reset
//   Addr_bus, Data_bus_out, R_nW   CPU access (R_nW=1 read)
//   Data_bus_in                    read data to the CPU (combinational)
//   cpu_rdy, dma_active            stall to the CPU / DMA busy
//   prg_addr, prg_data             cartridge PRG port
//   ppu_sel, ppu_addr, ppu_we,
//   ppu_wdata, ppu_rdata           PPU register port
module nes_cpu_bus_responder #(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter logic [2:0]  OAM_REG = 3'd4
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic [7:0]  Data_bus_out,
    input  logic        R_nW,
    output logic [7:0]  Data_bus_in,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data,
    output logic        ppu_sel,
    output logic [2:0]  ppu_addr,
    output logic        ppu_we,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata
);

    import nes_bus_pkg::*;

    logic [7:0]  ram [0:(1<<RAM_AW)-1];
    logic [7:0]  open_bus;

    logic        src_rd;
    logic [15:0] src_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;

    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_on;
    region_t     rgn;
    logic [7:0]  rd_data;
    logic        rd_driven;
    logic        cpu_wr;
    logic        dma_start;

    assign cpu_wr    = !dma_active && !R_nW;
    assign dma_start = cpu_wr && (Addr_bus == DMA_REG);
    assign cpu_rdy   = !dma_active;

    oam_dma_engine u_dma (
        .clk_ph1    (clk_ph1),
        .rst        (rst),
        .start      (dma_start),
        .start_page (Data_bus_out),
        .active     (dma_active),
        .src_rd     (src_rd),
        .src_addr   (src_addr),
        .src_data   (rd_data),
        .oam_we     (oam_we),
        .oam_wdata  (oam_wdata)
    );

    // The DMA read phase reuses the CPU-side decode; halt/align/write
    // cycles put nothing on the source side of the bus.
    always_comb begin
        bus_addr  = dma_active ? src_addr : Addr_bus;
        bus_rd    = dma_active || R_nW;
        bus_on    = !dma_active || src_rd;
        rgn       = decode_region(bus_addr, DMA_REG);
        rd_data   = open_bus;
        rd_driven = 1'b0;
        ppu_sel   = 1'b0;
        ppu_addr  = 3'd0;
        ppu_we    = 1'b0;
        ppu_wdata = 8'd0;
        prg_addr  = 15'd0;
        if (bus_on) begin
            case (rgn)
                RGN_RAM: begin
                    rd_data   = ram[bus_addr[RAM_AW-1:0]];
                    rd_driven = bus_rd;
                end
                RGN_PPU: begin
                    ppu_sel   = 1'b1;
                    ppu_addr  = bus_addr[2:0];
                    ppu_we    = !bus_rd;
                    ppu_wdata = bus_rd ? 8'd0 : Data_bus_out;
                    rd_data   = ppu_rdata;
                    rd_driven = bus_rd;
                end
                RGN_PRG: begin
                    prg_addr  = bus_addr[14:0];
                    rd_data   = prg_data;
                    rd_driven = bus_rd;
                end
                default: ;
            endcase
        end
        if (oam_we) begin
            ppu_sel   = 1'b1;
            ppu_addr  = OAM_REG;
            ppu_we    = 1'b1;
            ppu_wdata = oam_wdata;
        end
    end

    assign Data_bus_in = rd_data;

    always_ff @(posedge clk_ph1) begin
        if (rst)
            open_bus <= 8'd0;
        else if (rd_driven)
            open_bus <= rd_data;
        else if (cpu_wr)
            open_bus <= Data_bus_out;
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst && cpu_wr && (rgn == RGN_RAM))
            ram[Addr_bus[RAM_AW-1:0]] <= Data_bus_out;
    end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// tb/tb_nes_cpu_bus_responder.sv - randomized self-checking bench for nes_cpu_bus_responder
module tb_nes_cpu_bus_responder;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr_bus = 16'h0000;
    logic [7:0]  Data_bus_out = 8'h00;
    logic        R_nW = 1'b1;
    logic [7:0]  Data_bus_in;
    logic        cpu_rdy;
    logic        dma_active;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic        ppu_sel;
    logic [2:0]  ppu_addr;
    logic        ppu_we;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;

    int total = 0;
    int bad = 0;
    int we_count = 0;
    logic m_par = 1'b0;
    logic [7:0] ram_m [2048];

    always #5 clk_ph1 = ~clk_ph1;

    function automatic logic [7:0] ppu_model(input logic [2:0] r);
        return {r, 5'h0A} ^ 8'h93;
    endfunction

    assign prg_data  = prg_addr[7:0];
    assign ppu_rdata = ppu_model(ppu_addr);

    always @(posedge clk_ph1) m_par <= rst ? 1'b0 : ~m_par;
    always @(negedge clk_ph1) if (ppu_we === 1'b1) we_count++;

    nes_cpu_bus_responder dut (
        .clk_ph1      (clk_ph1),
        .rst          (rst),
        .Addr_bus     (Addr_bus),
        .Data_bus_out (Data_bus_out),
        .R_nW         (R_nW),
        .Data_bus_in  (Data_bus_in),
        .cpu_rdy      (cpu_rdy),
        .dma_active   (dma_active),
        .prg_addr     (prg_addr),
        .prg_data     (prg_data),
        .ppu_sel      (ppu_sel),
        .ppu_addr     (ppu_addr),
        .ppu_we       (ppu_we),
        .ppu_wdata    (ppu_wdata),
        .ppu_rdata    (ppu_rdata)
    );

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        Addr_bus = a; Data_bus_out = d; R_nW = 1'b0;
        @(posedge clk_ph1); #1;
        if (a < 16'h2000) ram_m[a % 2048] = d;
        Addr_bus = 16'h0000; Data_bus_out = 8'h00; R_nW = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        Addr_bus = a; R_nW = 1'b1;
        @(negedge clk_ph1);
        d = Data_bus_in;
        @(posedge clk_ph1); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; Addr_bus = 16'h4800; R_nW = 1'b1;
        repeat (3) @(posedge clk_ph1);
        @(negedge clk_ph1);
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_cpu_rdy got=%b exp=1", cpu_rdy); end
        total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL reset_dma_active got=%b exp=0", dma_active); end
        total++; if (ppu_we !== 1'b0 || ppu_sel !== 1'b0) begin bad++; $display("FAIL reset_ppu got=%b%b exp=00", ppu_sel, ppu_we); end
        total++; if (Data_bus_in !== 8'h00) begin bad++; $display("FAIL reset_open_bus got=%h exp=00", Data_bus_in); end
        @(posedge clk_ph1); #1;
        rst = 1'b0; Addr_bus = 16'h0000;
    endtask

    task automatic test_ram_mirror;
        logic [7:0] d;
        logic [15:0] a;
        logic [15:0] aq[$];
        cpu_write(16'h0012, 8'h55);
        cpu_read(16'h0812, d);
        total++; if (d !== 8'h55) begin bad++; $display("FAIL ram_mirror_0812 got=%h exp=55", d); end
        cpu_read(16'h1812, d);
        total++; if (d !== 8'h55) begin bad++; $display("FAIL ram_mirror_1812 got=%h exp=55", d); end
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 16'h1FFF));
            cpu_write(a, 8'($urandom));
            aq.push_back(a);
        end
        foreach (aq[i]) begin
            a = aq[i] ^ {3'b000, 2'($urandom), 11'h000};
            cpu_read(a, d);
            total++;
            if (d !== ram_m[a % 2048]) begin bad++; $display("FAIL ram_random addr=%h got=%h exp=%h", a, d, ram_m[a % 2048]); end
        end
    endtask

    task automatic test_prg;
        logic [7:0] d;
        logic [15:0] a;
        Addr_bus = 16'hFFFC; R_nW = 1'b1;
        @(negedge clk_ph1);
        total++; if (prg_addr !== 15'h7FFC) begin bad++; $display("FAIL prg_addr got=%h exp=7ffc", prg_addr); end
        total++; if (Data_bus_in !== 8'hFC) begin bad++; $display("FAIL prg_data got=%h exp=fc", Data_bus_in); end
        @(posedge clk_ph1); #1;
        Addr_bus = 16'h8000; Data_bus_out = 8'h11; R_nW = 1'b0;
        @(negedge clk_ph1);
        total++; if (ppu_sel !== 1'b0 || ppu_we !== 1'b0) begin bad++; $display("FAIL prg_write_ppu got=%b%b exp=00", ppu_sel, ppu_we); end
        @(posedge clk_ph1); #1;
        R_nW = 1'b1;
        cpu_read(16'h4800, d);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL open_bus_write_capture got=%h exp=11", d); end
        cpu_read(16'h0012, d);
        total++; if (d !== ram_m[12'h012]) begin bad++; $display("FAIL prg_write_ram got=%h exp=%h", d, ram_m[12'h012]); end
        for (int i = 0; i < 8; i++) begin
            a = 16'h8000 | 16'($urandom);
            Addr_bus = a;
            @(negedge clk_ph1);
            total++;
            if (prg_addr !== a[14:0] || Data_bus_in !== a[7:0]) begin
                bad++; $display("FAIL prg_random addr=%h got=%h/%h exp=%h/%h", a, prg_addr, Data_bus_in, a[14:0], a[7:0]);
            end
            @(posedge clk_ph1); #1;
        end
    endtask

    task automatic test_ppu;
        int wc;
        logic [15:0] a;
        logic [7:0] d;
        wc = we_count;
        Addr_bus = 16'h3FF9; Data_bus_out = 8'hA5; R_nW = 1'b0;
        @(negedge clk_ph1);
        total++;
        if (ppu_sel !== 1'b1 || ppu_addr !== 3'd1 || ppu_we !== 1'b1 || ppu_wdata !== 8'hA5) begin
            bad++; $display("FAIL ppu_write got=%b/%0d/%b/%h exp=1/1/1/a5", ppu_sel, ppu_addr, ppu_we, ppu_wdata);
        end
        @(posedge clk_ph1); #1;
        Addr_bus = 16'h0000; R_nW = 1'b1;
        repeat (3) @(negedge clk_ph1);
        total++; if (we_count - wc !== 1) begin bad++; $display("FAIL ppu_write_pulses got=%0d exp=1", we_count - wc); end
        @(posedge clk_ph1); #1;
        for (int i = 0; i < 6; i++) begin
            a = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
            d = 8'($urandom);
            Addr_bus = a; R_nW = 1'($urandom); Data_bus_out = d;
            @(negedge clk_ph1);
            total++;
            if (R_nW) begin
                if (ppu_sel !== 1'b1 || ppu_we !== 1'b0 || ppu_addr !== a[2:0] || Data_bus_in !== ppu_model(a[2:0])) begin
                    bad++; $display("FAIL ppu_read addr=%h got=%b/%b/%h exp data=%h", a, ppu_sel, ppu_we, Data_bus_in, ppu_model(a[2:0]));
                end
            end else begin
                if (ppu_sel !== 1'b1 || ppu_we !== 1'b1 || ppu_addr !== a[2:0] || ppu_wdata !== d) begin
                    bad++; $display("FAIL ppu_rand_write addr=%h got=%b/%b/%h exp=%h", a, ppu_sel, ppu_we, ppu_wdata, d);
                end
            end
            @(posedge clk_ph1); #1;
        end
        Addr_bus = 16'h0000; R_nW = 1'b1;
    endtask

    task automatic test_open_bus;
        logic [7:0] d;
        logic [7:0] v;
        logic [15:0] a;
        logic [15:0] oa;
        cpu_write(16'h0005, 8'h77);
        cpu_read(16'h0005, d);
        cpu_read(16'h4800, d);
        total++; if (d !== 8'h77) begin bad++; $display("FAIL open_bus_4800 got=%h exp=77", d); end
        cpu_read(16'h4014, d);
        total++; if (d !== 8'h77) begin bad++; $display("FAIL open_bus_4014 got=%h exp=77", d); end
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom_range(0, 16'h1FFF));
            v = 8'($urandom);
            cpu_write(a, v);
            cpu_read(a, d);
            oa = 16'($urandom_range(16'h4000, 16'h7FFF));
            if (oa == 16'h4014) oa = 16'h4015;
            cpu_read(oa, d);
            total++; if (d !== v) begin bad++; $display("FAIL open_bus_random addr=%h got=%h exp=%h", oa, d, v); end
        end
    endtask

    task automatic run_dma(input logic [7:0] page, input logic want_par,
                           input logic [15:0] ign_addr, input int reset_after);
        logic [7:0] exp_b [256];
        logic [15:0] s;
        int stall;
        int n;
        int wc;
        for (int i = 0; i < 256; i++) begin
            s = {page, 8'(i)};
            if (s < 16'h2000) exp_b[i] = ram_m[s % 2048];
            else              exp_b[i] = s[7:0];
        end
        // HALT sees the parity of the cycle after the trigger write.
        if (m_par == want_par) begin
            @(posedge clk_ph1); #1;
        end
        Addr_bus = 16'h4014; Data_bus_out = page; R_nW = 1'b0;
        @(posedge clk_ph1); #1;
        if (ign_addr != 16'h0000) begin
            Addr_bus = ign_addr; Data_bus_out = 8'hEE; R_nW = 1'b0;
        end else begin
            Addr_bus = 16'h0000; R_nW = 1'b1;
        end
        stall = 0; n = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk_ph1);
            if (cpu_rdy === 1'b1) break;
            stall++;
            if (ppu_we === 1'b1) begin
                total++;
                if (ppu_sel !== 1'b1 || ppu_addr !== 3'd4 || n > 255 || ppu_wdata !== exp_b[n[7:0]]) begin
                    bad++; $display("FAIL dma_write idx=%0d got=%0d/%h exp=4/%h", n, ppu_addr, ppu_wdata, exp_b[n[7:0]]);
                end
                n++;
                if (reset_after != 0 && n == reset_after) begin
                    rst = 1'b1;
                    break;
                end
            end
        end
        Addr_bus = 16'h0000; R_nW = 1'b1; Data_bus_out = 8'h00;
        if (reset_after != 0) begin
            @(posedge clk_ph1);
            @(negedge clk_ph1);
            total++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin bad++; $display("FAIL dma_reset got rdy=%b act=%b exp 1/0", cpu_rdy, dma_active); end
            rst = 1'b0;
            wc = we_count;
            repeat (600) @(negedge clk_ph1);
            total++; if (we_count != wc) begin bad++; $display("FAIL dma_reset_pulses got=%0d exp=0", we_count - wc); end
            total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL dma_reset_rdy got=%b exp=1", cpu_rdy); end
        end else begin
            total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL dma_timeout got rdy=%b exp=1", cpu_rdy); end
            total++; if (stall != (want_par ? 514 : 513)) begin bad++; $display("FAIL dma_stall par=%b got=%0d exp=%0d", want_par, stall, want_par ? 514 : 513); end
            total++; if (n != 256) begin bad++; $display("FAIL dma_pulses got=%0d exp=256", n); end
        end
        @(posedge clk_ph1); #1;
    endtask

    task automatic test_dma;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'h3C);
        cpu_write(16'h0300, 8'h5A);
        run_dma(8'h02, 1'b0, 16'h0000, 0);
        run_dma(8'h02, 1'b1, 16'h0300, 0);
        cpu_read(16'h0300, d);
        total++; if (d !== 8'h5A) begin bad++; $display("FAIL dma_cpu_write_ignored got=%h exp=5a", d); end
        run_dma(8'hC3, 1'($urandom), 16'h4014, 0);
        repeat (3) @(negedge clk_ph1);
        total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL dma_retrigger_ignored got=%b exp=0", dma_active); end
        @(posedge clk_ph1); #1;
    endtask

    task automatic test_dma_reset;
        logic [7:0] d;
        run_dma(8'h02, 1'($urandom), 16'h0000, 100);
        cpu_read(16'h0200, d);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL dma_reset_ram got=%h exp=3c", d); end
    endtask

    initial begin
        test_reset();
        test_ram_mirror();
        test_prg();
        test_ppu();
        test_open_bus();
        test_dma();
        test_dma_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
